// File: rtl/dma_arbiter_pkg.sv
// Shared definitions for the DMA arbiter: FSM state encodings and width helpers.
package dma_arbiter_pkg;

  // Arbiter FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StGrant   = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StBusy    = 3'd3;
  localparam logic [2:0] StAbort   = 3'd4;
  localparam logic [2:0] StRelease = 3'd5;

  // Width needed to index n items; never below 1 so a single-entry case still has a bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/dma_arbiter_rr_picker.sv
// Combinational round-robin priority picker: first eligible index at or after rr_ptr,
// scanning upward and wrapping modulo NUM_DEV.
module rr_picker
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned DEV_W   = idx_width(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] eligible,
  input  logic [DEV_W-1:0]   rr_ptr,
  output logic               found,
  output logic [DEV_W-1:0]   idx
);

  logic [DEV_W-1:0] cand;

  // Walk the devices starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      cand = DEV_W'((32'(rr_ptr) + k) % NUM_DEV);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one DMA controller among NUM_DEV devices, with descriptor
// latching, per-transfer handshake routing and a stall watchdog that resets the controller.
module dma_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_DEV  = 4,
  parameter int unsigned ADD_LEN  = 16,
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned DEV_W    = idx_width(NUM_DEV)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_DEV-1:0]             dev_en,
  input  logic [NUM_DEV-1:0]             dev_rqst,
  input  logic [NUM_DEV-1:0]             dev_rd_wr,
  input  logic [NUM_DEV*ADD_LEN-1:0]     dev_num_words,
  input  logic [NUM_DEV*(ADD_LEN+1)-1:0] dev_start_addr,
  input  logic [NUM_DEV-1:0]             dev_ack,
  input  logic [NUM_DEV*DATA_LEN-1:0]    dev_in,
  output logic [NUM_DEV-1:0]             dev_grant,
  output logic [NUM_DEV-1:0]             dev_dma_ack,
  output logic [NUM_DEV-1:0]             dev_end_flag,
  output logic [DATA_LEN-1:0]            dev_out,
  output logic                           ctrl_rqst,
  output logic                           ctrl_rd_wr,
  output logic [ADD_LEN-1:0]             ctrl_num_words,
  output logic [ADD_LEN:0]               ctrl_start_addr,
  output logic                           ctrl_dev_ack,
  output logic [DATA_LEN-1:0]            ctrl_dev_in,
  input  logic                           ctrl_dma_ack,
  input  logic                           ctrl_end_flag,
  input  logic [DATA_LEN-1:0]            ctrl_dev_out,
  output logic                           ctrl_reset,
  output logic                           busy,
  output logic                           err_valid,
  output logic [DEV_W-1:0]               err_dev
);

  localparam int unsigned      WdW     = idx_width(TIMEOUT);
  localparam logic [WdW-1:0]   WdMax   = WdW'(TIMEOUT - 1);
  localparam logic [DEV_W-1:0] LastDev = DEV_W'(NUM_DEV - 1);

  logic [2:0]          state_q, state_d;
  logic                abort_2nd_q, abort_2nd_d;
  logic [DEV_W-1:0]    sel_q, sel_d;
  logic [DEV_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [DEV_W-1:0]    err_dev_q, err_dev_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic                rd_wr_q, rd_wr_d;
  logic [ADD_LEN-1:0]  num_words_q, num_words_d;
  logic [ADD_LEN:0]    start_addr_q, start_addr_d;
  logic                ctrl_reset_q;

  logic                found;
  logic [DEV_W-1:0]    win_idx;
  logic                win_rd_wr;
  logic [ADD_LEN-1:0]  win_num_words;
  logic [ADD_LEN:0]    win_start_addr;
  logic                sel_dev_ack;
  logic [DATA_LEN-1:0] sel_dev_in;
  logic                in_grant, in_busy, in_abort;

  rr_picker #(
    .NUM_DEV (NUM_DEV),
    .DEV_W   (DEV_W)
  ) u_rr_picker (
    .eligible (dev_rqst & dev_en),
    .rr_ptr   (rr_ptr_q),
    .found    (found),
    .idx      (win_idx)
  );

  // Select the winner's descriptor and the current owner's handshake/data inputs.
  always_comb begin
    win_rd_wr      = 1'b0;
    win_num_words  = '0;
    win_start_addr = '0;
    sel_dev_ack    = 1'b0;
    sel_dev_in     = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (DEV_W'(i) == win_idx) begin
        win_rd_wr      = dev_rd_wr[i];
        win_num_words  = dev_num_words[i*ADD_LEN +: ADD_LEN];
        win_start_addr = dev_start_addr[i*(ADD_LEN+1) +: (ADD_LEN+1)];
      end
      if (DEV_W'(i) == sel_q) begin
        sel_dev_ack = dev_ack[i];
        sel_dev_in  = dev_in[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  // Next-state logic: arbitration, transfer tracking and watchdog.
  always_comb begin
    state_d      = state_q;
    abort_2nd_d  = abort_2nd_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    err_dev_d    = err_dev_q;
    wd_d         = wd_q;
    rd_wr_d      = rd_wr_q;
    num_words_d  = num_words_q;
    start_addr_d = start_addr_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d        = win_idx;
          rd_wr_d      = win_rd_wr;
          num_words_d  = win_num_words;
          start_addr_d = win_start_addr;
          state_d      = StGrant;
        end
      end
      StGrant: state_d = StIssue;
      StIssue: begin
        wd_d    = '0;
        state_d = StBusy;
      end
      StBusy: begin
        // End flag takes priority over a simultaneous watchdog expiry.
        if (ctrl_end_flag) begin
          state_d = StRelease;
        end else if (ctrl_dma_ack || sel_dev_ack) begin
          wd_d = '0;
        end else if (wd_q == WdMax) begin
          state_d     = StAbort;
          abort_2nd_d = 1'b0;
          err_dev_d   = sel_q;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StAbort: begin
        if (!abort_2nd_q) begin
          abort_2nd_d = 1'b1;
        end else begin
          abort_2nd_d = 1'b0;
          state_d     = StRelease;
        end
      end
      StRelease: begin
        rr_ptr_d = (sel_q == LastDev) ? '0 : sel_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; controller reset is held high through reset and both abort cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      abort_2nd_q  <= 1'b0;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      err_dev_q    <= '0;
      wd_q         <= '0;
      rd_wr_q      <= 1'b0;
      num_words_q  <= '0;
      start_addr_q <= '0;
      ctrl_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      abort_2nd_q  <= abort_2nd_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      err_dev_q    <= err_dev_d;
      wd_q         <= wd_d;
      rd_wr_q      <= rd_wr_d;
      num_words_q  <= num_words_d;
      start_addr_q <= start_addr_d;
      ctrl_reset_q <= (state_d == StAbort);
    end
  end

  // Output decode and zero-latency routing to the owning device.
  always_comb begin
    in_grant = (state_q == StGrant) || (state_q == StIssue) ||
               (state_q == StBusy) || (state_q == StAbort);
    in_busy  = (state_q == StBusy);
    in_abort = (state_q == StAbort);
    dev_grant    = '0;
    dev_dma_ack  = '0;
    dev_end_flag = '0;
    for (int unsigned i = 0; i < NUM_DEV; i++) begin
      if (DEV_W'(i) == sel_q) begin
        dev_grant[i]    = in_grant;
        dev_dma_ack[i]  = in_busy && ctrl_dma_ack;
        dev_end_flag[i] = (in_busy && ctrl_end_flag) || in_abort;
      end
    end
    ctrl_dev_ack    = in_busy && sel_dev_ack;
    ctrl_dev_in     = in_busy ? sel_dev_in : '0;
    dev_out         = ctrl_dev_out;
    ctrl_rqst       = (state_q == StIssue);
    ctrl_rd_wr      = rd_wr_q;
    ctrl_num_words  = num_words_q;
    ctrl_start_addr = start_addr_q;
    ctrl_reset      = ctrl_reset_q;
    busy            = (state_q != StIdle);
    err_valid       = in_abort && !abort_2nd_q;
    err_dev         = err_dev_q;
  end

endmodule
